// File: rtl/packet_pkg.sv
// Shared FIFO36 framing definitions for the packet transmit/receive path.
package packet_pkg;

  localparam int SOF_BIT   = 32;
  localparam int EOF_BIT   = 33;
  localparam int OCC_MSB   = 35;
  localparam int OCC_LSB   = 34;
  localparam int HDR_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } tx_state_t;

  // occ stays 0: every FIFO36 word carries four valid bytes.
  function automatic logic [35:0] f36_word(input logic sof, input logic eof, input logic [31:0] dat);
    logic [35:0] w;
    w = '0;
    w[OCC_MSB:OCC_LSB] = 2'b00;
    w[EOF_BIT] = eof;
    w[SOF_BIT] = sof;
    w[31:0] = dat;
    return w;
  endfunction

endpackage

// File: rtl/packet_tx_fifo.sv
// Synchronous fall-through word FIFO with occupancy count.
// Latency: written word visible at rd_dat the cycle after; no backpressure, wr_en while full without rd_en is ignored.
module packet_tx_fifo #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  output logic [DW-1:0] rd_dat,
  output logic [DW-1:0] rd_nxt_dat,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic          do_wr;
  logic          do_rd;

  assign full       = count[AW];
  assign empty      = (count == '0);
  assign do_rd      = rd_en && !empty;
  assign do_wr      = wr_en && (!full || do_rd);
  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign rd_dat     = mem[rd_ptr];
  // Second read port lets the owner register the word that follows the head.
  assign rd_nxt_dat = mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr_nxt;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_transmitter.sv
// Byte-stream to FIFO36 Ethernet framer; PACKET_TRANSMITTER_SEQ_EN stamps a frame sequence number into H3.
// Latency: a frame starts one cycle after its last payload word is buffered.
// Backpressure: none on data_in (overrun words dropped, overflow sticky); tx_f36 word held until dst_rdy.
module packet_transmitter
  import packet_pkg::*;
#(
  parameter int PAYLOAD_WORDS = 64,
  parameter int FIFO_AW       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_in_en,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  output logic [35:0] tx_f36_data,
  output logic        tx_f36_src_rdy,
  input  logic        tx_f36_dst_rdy,
  output logic        overflow,
  output logic [15:0] seq_num
);

  localparam int CNT_W = FIFO_AW + 1;
  localparam int WCW   = $clog2(PAYLOAD_WORDS + HDR_WORDS);

  logic [1:0]       byte_cnt;
  logic [23:0]      pack_q;
  logic             fifo_wr;
  logic [31:0]      fifo_wr_dat;
  logic             fifo_rd;
  logic [31:0]      fifo_rd_dat;
  logic [31:0]      fifo_rd_nxt_dat;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  tx_state_t        state;
  logic [WCW-1:0]   word_cnt;
  logic [WCW-1:0]   cnt_nxt;
  logic             xfer;
  logic             pay_last;
  logic             nxt_is_last;
  logic [31:0]      hdr [HDR_WORDS];

  // Bytes shift in MSB-first so the 4th byte completes the word combinationally.
  assign fifo_wr     = data_in_en && (byte_cnt == 2'd3);
  assign fifo_wr_dat = {pack_q, data_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      pack_q   <= '0;
    end else if (data_in_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      pack_q   <= {pack_q[15:0], data_in};
    end
  end

  packet_tx_fifo #(
    .DW(32),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (fifo_wr),
    .wr_dat     (fifo_wr_dat),
    .rd_en      (fifo_rd),
    .rd_dat     (fifo_rd_dat),
    .rd_nxt_dat (fifo_rd_nxt_dat),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (fifo_wr && fifo_full && !fifo_rd) overflow <= 1'b1;
  end

  always_comb begin
    hdr[0] = dst_mac[47:16];
    hdr[1] = {dst_mac[15:0], src_mac[47:32]};
    hdr[2] = src_mac[31:0];
    hdr[3] = {ethertype, seq_num};
  end

  assign xfer        = tx_f36_src_rdy && tx_f36_dst_rdy;
  assign fifo_rd     = xfer && (state == PAY);
  assign cnt_nxt     = word_cnt + WCW'(1);
  assign pay_last    = (word_cnt == WCW'(PAYLOAD_WORDS - 1));
  assign nxt_is_last = (cnt_nxt == WCW'(PAYLOAD_WORDS - 1));

  // The payload word on the bus is always the FIFO head; it is popped on its own transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      word_cnt       <= '0;
      tx_f36_src_rdy <= 1'b0;
      tx_f36_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_count >= CNT_W'(PAYLOAD_WORDS)) begin
            state          <= HDR;
            word_cnt       <= '0;
            tx_f36_src_rdy <= 1'b1;
            tx_f36_data    <= f36_word(1'b1, 1'b0, hdr[0]);
          end
        end
        HDR: begin
          if (xfer) begin
            if (word_cnt == WCW'(HDR_WORDS - 1)) begin
              state       <= PAY;
              word_cnt    <= '0;
              tx_f36_data <= f36_word(1'b0, PAYLOAD_WORDS == 1, fifo_rd_dat);
            end else begin
              word_cnt    <= cnt_nxt;
              tx_f36_data <= f36_word(1'b0, 1'b0, hdr[cnt_nxt[1:0]]);
            end
          end
        end
        PAY: begin
          if (xfer) begin
            if (pay_last) begin
              state          <= IDLE;
              word_cnt       <= '0;
              tx_f36_src_rdy <= 1'b0;
              tx_f36_data    <= '0;
            end else begin
              word_cnt    <= cnt_nxt;
              tx_f36_data <= f36_word(1'b0, nxt_is_last, fifo_rd_nxt_dat);
            end
          end
        end
        default: begin
          state          <= IDLE;
          tx_f36_src_rdy <= 1'b0;
          tx_f36_data    <= '0;
        end
      endcase
    end
  end

`ifdef PACKET_TRANSMITTER_SEQ_EN
  logic [15:0] seq_q;
  logic        frame_done;

  assign frame_done = fifo_rd && pay_last;
  assign seq_num    = seq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seq_q <= '0;
    else if (frame_done) seq_q <= seq_q + 16'd1;
  end
`else
  assign seq_num = 16'h0000;
`endif

endmodule

// File: tb/tb_packet_transmitter.sv
// Directed bench for packet_transmitter: small-payload instance plus a tiny-buffer instance for overrun.
module tb_packet_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din_a, din_o;
  logic        en_a, en_o;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype;
  logic [35:0] dat_a, dat_o;
  logic        srdy_a, srdy_o;
  logic        drdy_a, drdy_o;
  logic        ovf_a, ovf_o;
  logic [15:0] seq_a, seq_o;

  int          mode_a;
  int          mode_o;
  int          checks = 0;
  int          errors = 0;
  logic [35:0] cap_a[$];
  logic [35:0] cap_o[$];
  logic        hold_a = 1'b0, hold_o = 1'b0;
  logic [35:0] held_a, held_o;
  logic [15:0] exp_seq;

  always #5 clk = ~clk;

  packet_transmitter #(.PAYLOAD_WORDS(4), .FIFO_AW(8)) dut_a (
    .clk            (clk),
    .reset          (reset),
    .data_in        (din_a),
    .data_in_en     (en_a),
    .dst_mac        (dst_mac),
    .src_mac        (src_mac),
    .ethertype      (ethertype),
    .tx_f36_data    (dat_a),
    .tx_f36_src_rdy (srdy_a),
    .tx_f36_dst_rdy (drdy_a),
    .overflow       (ovf_a),
    .seq_num        (seq_a)
  );

  packet_transmitter #(.PAYLOAD_WORDS(8), .FIFO_AW(3)) dut_o (
    .clk            (clk),
    .reset          (reset),
    .data_in        (din_o),
    .data_in_en     (en_o),
    .dst_mac        (dst_mac),
    .src_mac        (src_mac),
    .ethertype      (ethertype),
    .tx_f36_data    (dat_o),
    .tx_f36_src_rdy (srdy_o),
    .tx_f36_dst_rdy (drdy_o),
    .overflow       (ovf_o),
    .seq_num        (seq_o)
  );

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sink ready: 0 = held low, 1 = held high, 2 = coin flip every cycle.
  always @(posedge clk) begin
    #1;
    drdy_a = (mode_a == 2) ? ($urandom_range(0, 1) == 1) : (mode_a == 1);
    drdy_o = (mode_o == 1);
  end

  always @(negedge clk) begin
    if (srdy_a && drdy_a) cap_a.push_back(dat_a);
    if (srdy_o && drdy_o) cap_o.push_back(dat_o);
    if (hold_a && srdy_a) check("hold_a", dat_a, held_a);
    if (hold_o && srdy_o) check("hold_o", dat_o, held_o);
    hold_a = srdy_a && !drdy_a;
    held_a = dat_a;
    hold_o = srdy_o && !drdy_o;
    held_o = dat_o;
  end

  function automatic logic [35:0] exp_word(input int idx, input int pw, input logic [7:0] base,
                                           input logic [15:0] seq);
    logic [7:0]  b;
    logic [15:0] s;
    logic [35:0] w;
`ifdef PACKET_TRANSMITTER_SEQ_EN
    s = seq;
`else
    s = 16'h0000;
`endif
    b = base + 8'((idx - 4) * 4);
    case (idx)
      0:       w = {4'b0001, dst_mac[47:16]};
      1:       w = {4'b0000, dst_mac[15:0], src_mac[47:32]};
      2:       w = {4'b0000, src_mac[31:0]};
      3:       w = {4'b0000, ethertype, s};
      default: w = {2'b00, (idx - 4 == pw - 1), 1'b0, b, b + 8'd1, b + 8'd2, b + 8'd3};
    endcase
    return w;
  endfunction

  task automatic feed_a(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      din_a = base + 8'(i);
      en_a  = 1'b1;
    end
    @(posedge clk); #1;
    en_a = 1'b0;
  endtask

  task automatic feed_o(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      din_o = base + 8'(i);
      en_o  = 1'b1;
    end
    @(posedge clk); #1;
    en_o = 1'b0;
  endtask

  task automatic wait_a(input int n, input string tag);
    for (int i = 0; i < 3000 && cap_a.size() < n; i++) @(negedge clk);
    check(tag, 36'(cap_a.size() >= n), 36'd1);
  endtask

  task automatic check_frame_a(input int off, input logic [7:0] base, input logic [15:0] seq);
    for (int i = 0; i < 8; i++)
      check($sformatf("frame_a@%0d", off + i), cap_a[off + i], exp_word(i, 4, base, seq));
  endtask

  logic [35:0] f1 [8];

  initial begin
    f1 = '{36'h1_00112233, 36'h0_44556677, 36'h0_8899AABB, 36'h0_08000000,
           36'h0_00010203, 36'h0_04050607, 36'h0_08090A0B, 36'h2_0C0D0E0F};
    dst_mac   = 48'h001122334455;
    src_mac   = 48'h66778899AABB;
    ethertype = 16'h0800;
    en_a = 1'b0; en_o = 1'b0; din_a = '0; din_o = '0;
    mode_a = 0; mode_o = 0;
    exp_seq = 16'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_srdy", 36'(srdy_a), 36'd0);
    check("rst_data", dat_a, 36'd0);
    check("rst_ovf", 36'(ovf_a), 36'd0);
    check("rst_seq", 36'(seq_a), 36'd0);
    check("rst_srdy_o", 36'(srdy_o), 36'd0);
    reset = 1'b0;

    // Basic frame with hand-computed words.
    mode_a = 1;
    feed_a(8'h00, 16);
    wait_a(8, "f1_cnt");
    for (int i = 0; i < 8; i++) check($sformatf("f1_w%0d", i), cap_a[i], f1[i]);
`ifdef PACKET_TRANSMITTER_SEQ_EN
    exp_seq = 16'd1;
`endif

    // Second frame: H3 carries the sequence number when enabled.
    cap_a.delete();
    feed_a(8'h10, 16);
    wait_a(8, "f2_cnt");
`ifdef PACKET_TRANSMITTER_SEQ_EN
    check("f2_h3", cap_a[3], 36'h0_08000001);
`else
    check("f2_h3", cap_a[3], 36'h0_08000000);
`endif
    check_frame_a(0, 8'h10, exp_seq);
    repeat (3) @(negedge clk);
`ifdef PACKET_TRANSMITTER_SEQ_EN
    exp_seq = 16'd2;
`endif
    check("f2_seq", 36'(seq_a), 36'(exp_seq));

    // Random sink backpressure over three frames.
    cap_a.delete();
    mode_a = 2;
    feed_a(8'h20, 48);
    wait_a(24, "bp_cnt");
    for (int f = 0; f < 3; f++) check_frame_a(f * 8, 8'h20 + 8'(f * 16), exp_seq + 16'(f));
    mode_a = 1;
    repeat (3) @(negedge clk);
    check("bp_ovf", 36'(ovf_a), 36'd0);

    // Overrun on the 8-deep instance.
    feed_o(8'h00, 32);
    repeat (3) @(negedge clk);
    check("ov_pre_ovf", 36'(ovf_o), 36'd0);
    check("ov_srdy", 36'(srdy_o), 36'd1);
    check("ov_h0", dat_o, 36'h1_00112233);
    feed_o(8'h20, 8);
    repeat (3) @(negedge clk);
    check("ov_ovf", 36'(ovf_o), 36'd1);
    mode_o = 1;
    for (int i = 0; i < 500 && cap_o.size() < 12; i++) @(negedge clk);
    check("ov_cnt", 36'(cap_o.size() >= 12), 36'd1);
    for (int i = 0; i < 12; i++)
      check($sformatf("ov_w%0d", i), cap_o[i], exp_word(i, 8, 8'h00, 16'h0000));
    repeat (20) @(negedge clk);
    check("ov_no_more", 36'(cap_o.size()), 36'd12);
    check("ov_idle", 36'(srdy_o), 36'd0);
    check("ov_sticky", 36'(ovf_o), 36'd1);

    // Reset in the middle of a payload.
    cap_a.delete();
    mode_a = 0;
    feed_a(8'h40, 16);
    for (int i = 0; i < 200 && !srdy_a; i++) @(negedge clk);
    check("mr_srdy_up", 36'(srdy_a), 36'd1);
    mode_a = 1;
    wait_a(6, "mr_cnt");
    #2;
    reset = 1'b1;
    #1;
    check("mr_srdy", 36'(srdy_a), 36'd0);
    check("mr_ovf_o", 36'(ovf_o), 36'd0);
    check("mr_seq", 36'(seq_a), 36'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cap_a.delete();
    exp_seq = 16'd0;
    feed_a(8'h80, 16);
    wait_a(8, "mr_f_cnt");
    check("mr_h0", cap_a[0], 36'h1_00112233);
    check_frame_a(0, 8'h80, exp_seq);

`ifdef PACKET_TRANSMITTER_SEQ_EN
    // Sequence number wrap.
    repeat (3) @(negedge clk);
    force dut_a.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.seq_q;
    cap_a.delete();
    feed_a(8'hA0, 32);
    wait_a(16, "wrap_cnt");
    check("wrap_h3_a", cap_a[3], 36'h0_0800FFFF);
    check("wrap_h3_b", cap_a[11], 36'h0_08000000);
    check_frame_a(8, 8'hB0, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
